// File: rtl/mt_sched_pkg.sv
// -----------------------------------------------------------------------------
// mt_sched_pkg
// Shared definitions for the multithreaded PC scheduler.
//   state_t          : scheduler FSM states (IDLE / RUN / DONE)
//   PC_STEP_DEFAULT  : default sequential fetch increment in bytes
//   SELF_LOOP_INSN   : encoding of `beq x0,x0,0`, the self-branch that halts a
//                      thread; benches use it to build halting programs
// -----------------------------------------------------------------------------
package mt_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          PC_STEP_DEFAULT = 4;
  localparam logic [31:0] SELF_LOOP_INSN  = 32'h00000063;

endpackage : mt_sched_pkg

// File: rtl/mt_pc_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Rotating-priority picker. It returns the first requester strictly after
// i_last, wrapping around. i_last itself has the lowest priority. N must be a
// power of two, so the index arithmetic wraps naturally at IDX_W bits.
// Ports:
//   i_req   [N-1:0]     request mask
//   i_last  [IDX_W-1:0] most recently granted index
//   o_grant [IDX_W-1:0] granted index (0 when nothing requests)
//   o_any               at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any
);

  // Scan from the farthest distance down to the nearest one. The last hit
  // written is the closest requester after i_last. Distance N truncates to 0,
  // so i_last itself is the final fallback.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    o_grant = '0;
    o_any   = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[i_last + IDX_W'(k)]) begin
        o_grant = i_last + IDX_W'(k);
        o_any   = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mt_pc_scheduler.sv
// -----------------------------------------------------------------------------
// mt_pc_scheduler
// Multithreaded PC file and barrel fetch scheduler. It holds one PC per thread.
// Each cycle it picks the next runnable thread in round-robin order and feeds
// its tid/pc to IF. It applies branch redirects from ID. A thread halts when it
// redirects to its own PC (a self-branch). The run ends (DONE) once every
// enabled thread has halted.
//
// Optional feature: define MT_PC_FETCH_CNT_EN to build per-thread 32-bit fetch
// counters. When it is undefined, fetch_cnt is tied to zero.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   start, thr_en            begin a run with the given thread mask (IDLE/DONE only)
//   init_we/init_tid/init_pc load one thread's start PC (IDLE/DONE only)
//   stall                    freeze selection and PC increment
//   redirect_*               ID-stage taken branch: thread, target, branch PC
//   fetch_valid/tid_if/pc_if fetch request to IF
//   halted                   per-thread halted or not-enabled flags
//   all_halted, busy         DONE / RUN state indicators
//   fetch_cnt                per-thread fetch counters, 32 bits each
// -----------------------------------------------------------------------------
module mt_pc_scheduler
  import mt_sched_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS),
  parameter int PC_W        = 11,
  parameter int PC_STEP     = PC_STEP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_THREADS-1:0]    thr_en,
  input  logic                      init_we,
  input  logic [TID_W-1:0]          init_tid,
  input  logic [PC_W-1:0]           init_pc,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [TID_W-1:0]          redirect_tid,
  input  logic [PC_W-1:0]           redirect_pc,
  input  logic [PC_W-1:0]           redirect_src_pc,
  output logic                      fetch_valid,
  output logic [TID_W-1:0]          tid_if,
  output logic [PC_W-1:0]           pc_if,
  output logic [NUM_THREADS-1:0]    halted,
  output logic                      all_halted,
  output logic                      busy,
  output logic [NUM_THREADS*32-1:0] fetch_cnt
);

  localparam logic [TID_W-1:0] LAST_RESET = TID_W'(NUM_THREADS - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [PC_W-1:0]          r_pc [NUM_THREADS];
  logic [NUM_THREADS-1:0]   r_halted;
  logic [TID_W-1:0]         r_last_tid;

  logic [TID_W-1:0]         w_sel;
  logic                     w_any;
  logic                     w_idle_or_done;
  logic                     w_start_acc;
  logic                     w_redir_take;
  logic [NUM_THREADS-1:0]   w_halt_mask;
  logic                     w_busy;
  logic                     w_all_halted;
  logic                     w_fetch;

  rr_pick #(
    .N     (NUM_THREADS),
    .IDX_W (TID_W)
  ) u_rr_pick (
    .i_req   (~r_halted),
    .i_last  (r_last_tid),
    .o_grant (w_sel),
    .o_any   (w_any)
  );

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_acc    = w_idle_or_done && start && (thr_en != '0);
  assign w_redir_take   = (r_state == ST_RUN) && redirect_valid && !r_halted[redirect_tid];
  // RUN always has a runnable thread. w_any only guards against an empty mask.
  assign w_fetch        = w_busy && w_any && !stall;

  // A self-branch marks its thread halted in the same update as the redirect.
  always_comb begin
    w_halt_mask = '0;
    if (w_redir_take && (redirect_pc == redirect_src_pc)) begin
      w_halt_mask[redirect_tid] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_all_halted = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        // The run ends when the halts recorded this cycle cover every thread.
        if (&(r_halted | w_halt_mask)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_all_halted = 1'b1;
        if (w_start_acc) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC file, halt flags and rotation pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the PC array is a small register file and must reset to zero,
      // so it is reset explicitly rather than left to a memory macro.
      for (int i = 0; i < NUM_THREADS; i++) r_pc[i] <= '0;
      r_halted   <= '0;
      r_last_tid <= LAST_RESET;
    end else begin
      // NOTE: these writes are ordered so the later one wins when they hit the
      // same thread. A redirect overrides the sequential increment.
      if (w_idle_or_done && init_we) r_pc[init_tid] <= init_pc;
      if (w_fetch) begin
        r_pc[w_sel] <= r_pc[w_sel] + PC_W'(PC_STEP);
        r_last_tid  <= w_sel;
      end
      if (w_redir_take) r_pc[redirect_tid] <= redirect_pc;

      if (w_start_acc) begin
        r_halted   <= ~thr_en;
        r_last_tid <= LAST_RESET;
      end else begin
        r_halted <= r_halted | w_halt_mask;
      end
    end
  end

  assign fetch_valid = w_fetch;
  assign tid_if      = w_sel;
  assign pc_if       = r_pc[w_sel];
  assign halted      = r_halted;
  assign all_halted  = w_all_halted;
  assign busy        = w_busy;

  // ---------------------------------------------------------------------------
  // Optional per-thread fetch counters
  // ---------------------------------------------------------------------------
`ifdef MT_PC_FETCH_CNT_EN
  logic [31:0] r_cnt [NUM_THREADS];

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      for (int i = 0; i < NUM_THREADS; i++) r_cnt[i] <= '0;
    end else if (w_fetch) begin
      r_cnt[w_sel] <= r_cnt[w_sel] + 32'd1;
    end
  end

  always_comb begin
    fetch_cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) fetch_cnt[i*32 +: 32] = r_cnt[i];
  end
`else
  assign fetch_cnt = '0;
`endif

endmodule : mt_pc_scheduler

// File: tb/tb_mt_pc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mt_pc_scheduler
// Self-checking bench for mt_pc_scheduler with 4 threads and an 11-bit PC.
// A behavioural model keeps per-thread PCs, halt flags, the last-fetched
// thread, the run state and the fetch counts. It predicts every output each
// cycle. Directed scenarios come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_mt_pc_scheduler;

  localparam int NT   = 4;
  localparam int PCW  = 11;
  localparam int STEP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NT-1:0]   thr_en;
  logic            init_we;
  logic [1:0]      init_tid;
  logic [PCW-1:0]  init_pc;
  logic            stall;
  logic            redirect_valid;
  logic [1:0]      redirect_tid;
  logic [PCW-1:0]  redirect_pc;
  logic [PCW-1:0]  redirect_src_pc;
  logic            fetch_valid;
  logic [1:0]      tid_if;
  logic [PCW-1:0]  pc_if;
  logic [NT-1:0]   halted;
  logic            all_halted;
  logic            busy;
  logic [NT*32-1:0] fetch_cnt;

  mt_pc_scheduler #(
    .NUM_THREADS (NT),
    .PC_W        (PCW),
    .PC_STEP     (STEP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .thr_en          (thr_en),
    .init_we         (init_we),
    .init_tid        (init_tid),
    .init_pc         (init_pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_tid    (redirect_tid),
    .redirect_pc     (redirect_pc),
    .redirect_src_pc (redirect_src_pc),
    .fetch_valid     (fetch_valid),
    .tid_if          (tid_if),
    .pc_if           (pc_if),
    .halted          (halted),
    .all_halted      (all_halted),
    .busy            (busy),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Run states: 0 idle, 1 run, 2 done.
  // ---------------------------------------------------------------------------
  int             m_state;
  logic [PCW-1:0] m_pc [NT];
  logic [NT-1:0]  m_halted;
  int             m_last;
  int             m_cnt [NT];

  // Values the DUT showed in the most recent step, used by directed checks.
  logic [PCW-1:0] obs_pc;
  logic [1:0]     obs_tid;

  function automatic int model_sel();
    for (int k = 1; k <= NT; k++) begin
      if (!m_halted[(m_last + k) % NT]) return (m_last + k) % NT;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_halted = '0;
    m_last   = NT - 1;
    for (int i = 0; i < NT; i++) begin
      m_pc[i]  = '0;
      m_cnt[i] = 0;
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // advance the model with the inputs held this cycle, then cross the rising
  // edge. Inputs are changed by the caller 1 time unit after that edge.
  task automatic step();
    int   sel;
    logic exp_fv;
    logic idle_done;
    logic acc;
    @(negedge clk);
    sel    = model_sel();
    exp_fv = (m_state == 1) && !stall;
    obs_pc  = pc_if;
    obs_tid = tid_if;
    check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    if (m_halted != '1) check("tid_if", 32'(tid_if), 32'(sel));
    if (exp_fv)         check("pc_if", 32'(pc_if), 32'(m_pc[sel]));
    check("halted", 32'(halted), 32'(m_halted));
    check("all_halted", 32'(all_halted), 32'(m_state == 2));
    check("busy", 32'(busy), 32'(m_state == 1));
    for (int i = 0; i < NT; i++) begin
`ifdef MT_PC_FETCH_CNT_EN
      check("fetch_cnt", fetch_cnt[i*32 +: 32], 32'(m_cnt[i]));
`else
      check("fetch_cnt", fetch_cnt[i*32 +: 32], 32'd0);
`endif
    end

    if (rst) begin
      model_reset();
    end else begin
      idle_done = (m_state != 1);
      acc       = idle_done && start && (thr_en != '0);
      if (idle_done && init_we) m_pc[init_tid] = init_pc;
      if (exp_fv) begin
        m_pc[sel] = PCW'((int'(m_pc[sel]) + STEP) % (1 << PCW));
        m_last    = sel;
        m_cnt[sel]++;
      end
      if (m_state == 1 && redirect_valid && !m_halted[redirect_tid]) begin
        m_pc[redirect_tid] = redirect_pc;
        if (redirect_pc == redirect_src_pc) m_halted[redirect_tid] = 1'b1;
      end
      if (acc) begin
        m_state  = 1;
        m_halted = ~thr_en;
        m_last   = NT - 1;
        for (int i = 0; i < NT; i++) m_cnt[i] = 0;
      end else if (m_state == 1 && m_halted == '1) begin
        m_state = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; init_we = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic self_loop(input logic [1:0] t, input logic [PCW-1:0] pc);
    redirect_valid = 1'b1; redirect_tid = t; redirect_pc = pc; redirect_src_pc = pc;
  endtask

  logic [PCW-1:0] rr_pc_tab  [10] = '{11'h000, 11'h008, 11'h010, 11'h018, 11'h004,
                                      11'h00C, 11'h014, 11'h01C, 11'h008, 11'h040};
  logic [1:0]     halt_order [4]  = '{2'd2, 2'd0, 2'd3, 2'd1};

  initial begin
    model_reset();
    rst = 1'b1; thr_en = '0; init_tid = '0; init_pc = '0;
    redirect_tid = '0; redirect_pc = '0; redirect_src_pc = '0;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
    step();
    check("reset_pc_if", 32'(pc_if), 32'd0);
    check("reset_tid_if", 32'(tid_if), 32'd0);

    // Round robin from 0/8/16/24 with a redirect collision on T1 at 0x0C.
    for (int t = 0; t < NT; t++) begin
      init_we = 1'b1; init_tid = 2'(t); init_pc = PCW'(t * 8);
      step();
    end
    idle_inputs();
    start = 1'b1; thr_en = 4'hF;
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        redirect_valid = 1'b1; redirect_tid = 2'd1;
        redirect_pc = 11'h040; redirect_src_pc = 11'h00C;
      end
      step();
      redirect_valid = 1'b0;
      check("rr_pc", 32'(obs_pc), 32'(rr_pc_tab[i]));
      check("rr_tid", 32'(obs_tid), 32'(i % NT));
    end

    // Three stalled cycles, then the rotation resumes where it stopped.
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (4) step();

    // Self-loop halts in the order T2, T0, T3, T1.
    for (int i = 0; i < NT; i++) begin
      self_loop(halt_order[i], 11'h07C);
      step();
      redirect_valid = 1'b0;
      check("halt_bit", 32'(halted[halt_order[i]]), 32'd1);
      step();
    end
    check("all_halted_done", 32'(all_halted), 32'd1);

    // Restart from DONE with a freshly written PC, covering the wrap at 0x7FC.
    init_we = 1'b1; init_tid = 2'd0; init_pc = 11'h7FC;
    start = 1'b1; thr_en = 4'b0001;
    step();
    idle_inputs();
    step();
    check("wrap_pc0", 32'(obs_pc), 32'h7FC);
    step();
    check("wrap_pc1", 32'(obs_pc), 32'h000);
    self_loop(2'd0, 11'h010);
    step();
    idle_inputs();
    start = 1'b1; thr_en = 4'b0000;
    step();
    idle_inputs();
    check("empty_start_busy", 32'(busy), 32'd0);

    // Masked run with only T0 and T2.
    start = 1'b1; thr_en = 4'b0101;
    step();
    idle_inputs();
    repeat (6) step();
    check("mask_halted", 32'(halted), 32'hA);

    // Reset in the middle of a run.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_fv", 32'(fetch_valid), 32'd0);
    check("midrst_pc", 32'(pc_if), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);

    // Twelve fetches over four threads.
    start = 1'b1; thr_en = 4'hF;
    step();
    idle_inputs();
    repeat (12) step();
    for (int i = 0; i < NT; i++) begin
`ifdef MT_PC_FETCH_CNT_EN
      check("cnt12", fetch_cnt[i*32 +: 32], 32'd3);
`else
      check("cnt12", fetch_cnt[i*32 +: 32], 32'd0);
`endif
    end

    // Randomized phase.
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(99) == 0);
      stall           = ($urandom_range(3) == 0);
      redirect_valid  = ($urandom_range(4) == 0);
      redirect_tid    = 2'($urandom);
      redirect_src_pc = PCW'($urandom);
      redirect_pc     = ($urandom_range(3) == 0) ? redirect_src_pc : PCW'($urandom);
      start           = ($urandom_range(7) == 0);
      thr_en          = 4'($urandom);
      init_we         = ($urandom_range(5) == 0);
      init_tid        = 2'($urandom);
      init_pc         = PCW'($urandom);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mt_pc_scheduler

// File: doc/mt_pc_scheduler.md
# mt_pc_scheduler

Parametrised multithreaded PC file and fetch scheduler for the barrel pipeline. It generalises the fixed 4-thread PC array to `NUM_THREADS` threads and a configurable PC width, and adds three things:
- an enable mask and start/stop control;
- a stall input;
- automatic per-thread halt on a self-branch (`beq x0,x0,0`), with an all-halted flag.

It sits in front of the instruction memory and feeds `tid`/`pc` to the IF stage. It takes branch redirects back from ID.

## Interface
- `NUM_THREADS`, 4: thread count, power of two, 2..16
- `TID_W`, `$clog2(NUM_THREADS)`: thread-id width
- `PC_W`, 11: byte-address PC width
- `PC_STEP`, 4: sequential increment in bytes
- `clk` in 1: clock; the single clock domain
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: one-cycle pulse that begins a run; accepted in IDLE or DONE only
- `thr_en` in `NUM_THREADS`: threads to run; sampled on an accepted `start`
- `init_we` in 1: loads the start PC of one thread; accepted in IDLE or DONE only
- `init_tid` in `TID_W`: thread whose PC is loaded
- `init_pc` in `PC_W`: PC value loaded
- `stall` in 1: freezes selection and PC update
- `redirect_valid` in 1: ID-stage taken branch/jump
- `redirect_tid` in `TID_W`: thread of the redirect
- `redirect_pc` in `PC_W`: redirect target
- `redirect_src_pc` in `PC_W`: PC of the branch instruction itself
- `fetch_valid` out 1: `tid_if`/`pc_if` are valid this cycle
- `tid_if` out `TID_W`: selected thread
- `pc_if` out `PC_W`: fetch PC of the selected thread
- `halted` out `NUM_THREADS`: per-thread halted or not-enabled flag
- `all_halted` out 1: high in DONE
- `busy` out 1: high in RUN
- `fetch_cnt` out `NUM_THREADS*32`: per-thread fetch counters (see Configuration)

## Operation
- **States**
  - IDLE: the reset state.
  - RUN: entered from IDLE or DONE on `start` with `thr_en != 0`. A `start` with `thr_en == 0` is ignored.
  - DONE: entered from RUN when every enabled thread has halted.
  - RUN is left only via DONE or `rst`.
- **On an accepted `start`:** `halted <= ~thr_en`; the rotation pointer `last_tid <= NUM_THREADS-1`. Thread PCs are not changed.
- **Selection.** `sel` is the first thread after `last_tid`, in rotating order, that has `halted == 0`. It is combinational from registered state.
  - `fetch_valid = busy & ~stall`.
  - `tid_if = sel`; `pc_if = pc_thr[sel]`.
  - With one runnable thread, that thread is selected every cycle.
- **On a posedge with `fetch_valid`:** `pc_thr[sel] <= pc_thr[sel] + PC_STEP`, wrapping modulo 2^`PC_W`; `last_tid <= sel`.
- **Redirect.** Taken only in RUN, and only when `halted[redirect_tid] == 0`; otherwise ignored.
  - Effect: `pc_thr[redirect_tid] <= redirect_pc`.
  - Stall does not block a redirect.
  - If the same thread is also incremented in that cycle, the redirect wins.
- **Self-loop halt.** A redirect with `redirect_pc == redirect_src_pc` also sets `halted[redirect_tid]`. That thread is excluded from selection from the next cycle on.
  - When the last non-halted thread halts, the next state is DONE.
  - In DONE, `fetch_valid = 0`.
- **`init_we`.** Writes `pc_thr[init_tid] <= init_pc` in IDLE or DONE; ignored in RUN. If `start` and `init_we` occur in the same cycle, the write is applied and the run then begins from the written PC.
- **Reset values** (also on reset mid-run): state IDLE, all `pc_thr` = 0, `halted` = 0, `last_tid` = `NUM_THREADS-1`. All outputs are 0 except `tid_if`, which shows `sel` = 0.

## Timing
- `start` at edge N: `fetch_valid` is high in the cycle after edge N.
- A redirect presented in cycle C takes effect at the end of cycle C. The new PC is seen at the thread's next selection.
- A halt presented in cycle C:
  - `halted` is high from cycle C+1.
  - `all_halted` is high in cycle C+1 if that was the last thread.
- Latency from stall deassertion to fetch: 0 cycles.

## Configuration
- **`MT_PC_FETCH_CNT_EN` defined:** per-thread 32-bit counter.
  - Increments when its thread is fetched (`fetch_valid` and `sel == i`).
  - Cleared on `rst` and on an accepted `start`.
  - Wraps at 2^32.
- **Not defined:** `fetch_cnt` is tied to 0 and no counter registers are built.

## Structure
- **Package `mt_sched_pkg`:** state enum (IDLE/RUN/DONE), the `PC_STEP` default, and the self-loop halt encoding constant `32'h00000063`, used by benches.
- **Sub-module `rr_pick`:** parametrised rotating-priority picker. Inputs: request mask and `last` index. Outputs: grant index and `any`.

## Test plan
- **Round robin.** Start PCs 0/8/16/24, `thr_en = 4'hF`, no stalls → fetches T0@0, T1@8, T2@16, T3@24, T0@4, T1@12, …
- **Mask and stall.**
  - `thr_en = 4'b0101` → T0/T2 alternate and `halted = 4'b1010`.
  - `stall` for 3 cycles → no PC change and order preserved.
- **Redirect collision.** Redirect T1 to 0x40 in the cycle T1 is fetched at 0x0C → T1's next fetch is at 0x40, not 0x10.
- **Halt sequence.**
  - Self-loop redirects for T2, T0, T3, T1 (`pc == src_pc = 0x7C`) → halted bits set one cycle later each.
  - Selection skips halted threads.
  - `all_halted` is high one cycle after T1's redirect.
- **Wrap and restart.**
  - PC 0x7FC increments to 0x000.
  - In DONE, `init_we` plus `start` reruns from the new PC.
- **Reset and counters.**
  - `rst` mid-RUN → IDLE, PCs 0, `fetch_valid` 0.
  - With `MT_PC_FETCH_CNT_EN`, 12 fetches over 4 threads → each counter reads 3.
